// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 configuration ROM and turns each entry into one SCCB register write.
// Reserved entries: 16'hFFF0 stalls for DELAY_CYCLES, 16'hFFFF ends the pass.
module ov7670_config_sequencer #(
    parameter int unsigned DELAY_CYCLES = 1000000,
    parameter int unsigned CNT_W        = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  rom_addr,
    output logic        rom_clk_en,
    input  logic [15:0] rom_dout,
    input  logic        sccb_ready,
    output logic        sccb_start,
    output logic [7:0]  sccb_reg,
    output logic [7:0]  sccb_data,
    output logic        busy,
    output logic        done
);

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned ENTRY_W = 16;

    localparam logic [ENTRY_W-1:0] TOK_DELAY = 16'hFFF0;
    localparam logic [ENTRY_W-1:0] TOK_END   = 16'hFFFF;
    localparam logic [ADDR_W-1:0]  ADDR_LAST = 8'hFF;
    localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(DELAY_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_DECODE,
        S_SEND,
        S_WAIT_ACK,
        S_DELAY,
        S_DONE
    } state_t;

    state_t             state, state_nx;
    logic [ENTRY_W-1:0] entry, entry_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               ack_armed, ack_armed_nx;

    logic [ADDR_W-1:0]  rom_addr_nx;
    logic               rom_clk_en_nx;
    logic               sccb_start_nx;
    logic [7:0]         sccb_reg_nx;
    logic [7:0]         sccb_data_nx;
    logic               busy_nx;
    logic               done_nx;
    logic               advance;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            entry      <= '0;
            cnt        <= '0;
            ack_armed  <= 1'b0;
            rom_addr   <= '0;
            rom_clk_en <= 1'b0;
            sccb_start <= 1'b0;
            sccb_reg   <= '0;
            sccb_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            entry      <= entry_nx;
            cnt        <= cnt_nx;
            ack_armed  <= ack_armed_nx;
            rom_addr   <= rom_addr_nx;
            rom_clk_en <= rom_clk_en_nx;
            sccb_start <= sccb_start_nx;
            sccb_reg   <= sccb_reg_nx;
            sccb_data  <= sccb_data_nx;
            busy       <= busy_nx;
            done       <= done_nx;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx      = state;
        entry_nx      = entry;
        cnt_nx        = cnt;
        ack_armed_nx  = 1'b0;
        rom_addr_nx   = rom_addr;
        rom_clk_en_nx = 1'b0;
        sccb_start_nx = 1'b0;
        sccb_reg_nx   = sccb_reg;
        sccb_data_nx  = sccb_data;
        busy_nx       = busy;
        done_nx       = done;
        advance       = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    rom_addr_nx   = '0;
                    busy_nx       = 1'b1;
                    done_nx       = 1'b0;
                    rom_clk_en_nx = 1'b1;
                    state_nx      = S_FETCH;
                end
            end
            S_FETCH: begin
                state_nx = S_LATCH;
            end
            S_LATCH: begin
                entry_nx = rom_dout;
                state_nx = S_DECODE;
            end
            S_DECODE: begin
                if (entry == TOK_END) begin
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = S_DONE;
                end else if (entry == TOK_DELAY) begin
                    cnt_nx   = CNT_LOAD;
                    state_nx = S_DELAY;
                end else begin
                    sccb_reg_nx  = entry[15:8];
                    sccb_data_nx = entry[7:0];
                    state_nx     = S_SEND;
                end
            end
            S_SEND: begin
                if (sccb_ready) begin
                    sccb_start_nx = 1'b1;
                    state_nx      = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // First cycle is the master's turnaround; its ready is stale
                ack_armed_nx = 1'b1;
                if (ack_armed && sccb_ready) begin
                    advance = 1'b1;
                end
            end
            S_DELAY: begin
                if (cnt == '0) begin
                    advance = 1'b1;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Address saturates at the last ROM slot instead of wrapping
        if (advance) begin
            if (rom_addr == ADDR_LAST) begin
                busy_nx  = 1'b0;
                done_nx  = 1'b1;
                state_nx = S_DONE;
            end else begin
                rom_addr_nx   = rom_addr + ADDR_W'(1);
                rom_clk_en_nx = 1'b1;
                state_nx      = S_FETCH;
            end
        end
    end

endmodule

// File: doc/ov7670_config_sequencer.md
Name: ov7670_config_sequencer

Overview:
- Walks the OV7670 configuration ROM from address 0 and turns each 16-bit entry into one SCCB register write request.
- Sits between the config ROM and the SCCB master.
- ROM entry encoding: [15:8] = register, [7:0] = value.
- Reserved tokens: 16'hFFF0 inserts a programmable delay; 16'hFFFF terminates the sequence.
- Raises done when the camera is fully configured, which gates the downstream pixel capture path.

Parameters:
- DELAY_CYCLES, 1000000: clock cycles to wait on a 16'hFFF0 token; must be at least 1.
- CNT_W, 20: delay counter width; must satisfy 2^CNT_W > DELAY_CYCLES.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a configuration pass from address 0
- rom_addr  output  8  ROM address
- rom_clk_en  output  1  ROM read enable; ROM registers dout on the next clk edge
- rom_dout  input  16  ROM data, valid the cycle after rom_clk_en
- sccb_ready  input  1  SCCB master idle and able to accept a request
- sccb_start  output  1  one-cycle write request pulse
- sccb_reg  output  8  register address, held from sccb_start until the next request
- sccb_data  output  8  register value, held the same way as sccb_reg
- busy  output  1  high from the accepted start until DONE or IDLE
- done  output  1  high in DONE; stays high until the next start or reset

Behaviour:
- Reset (asynchronous, rst_n low):
  - rom_addr=0, rom_clk_en=0, sccb_start=0, sccb_reg=0, sccb_data=0, busy=0, done=0.
  - Delay counter cleared; state=IDLE.
  - Applies at any point, including mid-transaction; no partial SCCB request is reissued afterwards.
- States: IDLE, FETCH, LATCH, DECODE, SEND, WAIT_ACK, DELAY, DONE.
- IDLE / DONE:
  - start=1 -> rom_addr=0, busy=1, done=0, go to FETCH.
  - start in any other state is ignored.
- FETCH:
  - rom_clk_en=1 for exactly one cycle with rom_addr stable -> LATCH.
  - rom_addr does not change between FETCH and the following DECODE.
- LATCH:
  - Capture rom_dout into an internal entry register -> DECODE.
  - Latency from FETCH to data available is 1 cycle.
- DECODE (priority order):
  - entry==16'hFFFF -> DONE: busy=0, done=1.
  - entry==16'hFFF0 -> load counter with DELAY_CYCLES-1 -> DELAY.
  - any other value -> sccb_reg=entry[15:8], sccb_data=entry[7:0] -> SEND.
- SEND:
  - Wait until sccb_ready=1, then pulse sccb_start for one cycle -> WAIT_ACK.
  - Never asserts sccb_start while sccb_ready=0.
- WAIT_ACK:
  - Ignore sccb_ready in the first cycle after the pulse, which is the master's turnaround.
  - From the second cycle, on sccb_ready=1 -> ADVANCE.
- DELAY:
  - Counter decrements each cycle; on reaching 0 -> ADVANCE.
  - Total stall is exactly DELAY_CYCLES cycles counted from DECODE exit.
- ADVANCE (an action, not a state):
  - rom_addr==255 -> DONE: busy=0, done=1. The address saturates and never wraps, even with no terminator.
  - Otherwise rom_addr+1 -> FETCH.
- Timing: minimum per-write overhead excluding SCCB time is FETCH+LATCH+DECODE+SEND+2 = 6 cycles.
- Simultaneous start and rst_n low: reset wins.
- The sequencer never reads the ROM while an SCCB request is outstanding.

Test Plan:
- ROM model {0:1280, 1:1204, 2:FFFF}; sccb_ready returns high 10 cycles after each start; pulse start:
  - exactly 2 sccb_start pulses, reg/data 12/80 then 12/04;
  - done=1 and busy=0 after address 2; rom_addr=2.
- ROM {0:1280, 1:FFF0, 2:1104, 3:FFFF}, DELAY_CYCLES=16:
  - gap between first WAIT_ACK completion and FETCH of address 2 includes exactly 16 DELAY cycles;
  - second write is 11/04.
- ROM {0:FFFF}; start -> zero sccb_start pulses; done=1 within 4 cycles.
- Back-pressure: hold sccb_ready=0 for 50 cycles in SEND -> no sccb_start pulse; pulse occurs the cycle after ready rises; reg/data stable throughout.
- Assert start during a write; separately, drop rst_n during WAIT_ACK:
  - start while busy has no effect; sequence unchanged.
  - reset returns all outputs to reset values immediately;
  - a new start replays from address 0.
- ROM filled with 16'h0101 (no terminator):
  - exactly 256 writes, then done=1 with rom_addr=255;
  - a second start reruns all 256 writes.
